multicycle_control_fsm: RTL and testbench

Multi-cycle RV32I-subset controller that sequences the shared datapath (PC, instruction register, single unified memory port, ALU, register file) across several clock cycles per instruction. It replaces single-cycle decode with an FSM that reuses the ALU for PC+4 and branch-target computation. It handshakes with a variable-latency memory through req/ready. It also exposes retire, illegal-op and memory-stall statistics for the testbench and a debug display.

---
 rtl/ctrl_pkg.sv | 67 ++++++
 rtl/ctrl_output_decoder.sv | 89 ++++++++
 rtl/multicycle_control_fsm.sv | 111 +++++++++++
 tb/tb_multicycle_control_fsm.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : ctrl_pkg
// Brief   : Shared types and encodings for the multi-cycle RV32I controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        ILLEGAL  = 4'd10
    } state_t;

    localparam logic [6:0] c_op_lw    = 7'b0000011;
    localparam logic [6:0] c_op_sw    = 7'b0100011;
    localparam logic [6:0] c_op_rtype = 7'b0110011;
    localparam logic [6:0] c_op_addi  = 7'b0010011;
    localparam logic [6:0] c_op_beq   = 7'b1100011;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;

    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rs1   = 2'b10;

    localparam logic [1:0] c_srcb_rs2  = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

    localparam logic [1:0] c_res_aluout    = 2'b00;
    localparam logic [1:0] c_res_memdata   = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;

    localparam logic [1:0] c_imm_i = 2'b00;
    localparam logic [1:0] c_imm_s = 2'b01;
    localparam logic [1:0] c_imm_b = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_word_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_output_decoder.sv
//------------------------------------------------------------------------------
// Module  : ctrl_output_decoder
// Brief   : Combinational map from controller state (plus gating inputs) to
//           the datapath control word.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_output_decoder
    import ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl             = '0;
        ctrl.alu_control = c_alu_add;
        case (state_t'(state))
            FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = c_srca_pc;
                ctrl.alu_src_b  = c_srcb_four;
                ctrl.result_src = c_res_aluresult;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            DECODE: begin
                // Branch target is precomputed into ALUOut for BEQ.
                ctrl.alu_src_a = c_srca_oldpc;
                ctrl.alu_src_b = c_srcb_imm;
                ctrl.imm_src   = c_imm_b;
            end
            MEMADR: begin
                ctrl.alu_src_a = c_srca_rs1;
                ctrl.alu_src_b = c_srcb_imm;
                ctrl.imm_src   = (op == c_op_sw) ? c_imm_s : c_imm_i;
            end
            MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            MEMWB: begin
                ctrl.result_src = c_res_memdata;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWRITE: begin
                ctrl.mem_req    = 1'b1;
                ctrl.mem_we     = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            EXECR: begin
                ctrl.alu_src_a = c_srca_rs1;
                ctrl.alu_src_b = c_srcb_rs2;
            end
            EXECI: begin
                ctrl.alu_src_a = c_srca_rs1;
                ctrl.alu_src_b = c_srcb_imm;
                ctrl.imm_src   = c_imm_i;
            end
            ALUWB: begin
                ctrl.result_src = c_res_aluout;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BEQ: begin
                ctrl.alu_src_a   = c_srca_rs1;
                ctrl.alu_src_b   = c_srcb_rs2;
                ctrl.alu_control = c_alu_sub;
                ctrl.result_src  = c_res_aluout;
                ctrl.pc_write    = zero;
                ctrl.instr_done  = 1'b1;
            end
            ILLEGAL: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
//------------------------------------------------------------------------------
// Module  : multicycle_control_fsm
// Brief   : Multi-cycle RV32I-subset controller: state register, next-state
//           logic and saturating memory-stall counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             op,
    input  logic                   zero,
    input  logic                   memReady,
    output logic                   memReq,
    output logic                   memWe,
    output logic                   AdrSrc,
    output logic                   IRWrite,
    output logic                   PCWrite,
    output logic                   RegWrite,
    output logic [1:0]             ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [2:0]             ALUControl,
    output logic [1:0]             ResultSrc,
    output logic [1:0]             ImmSrc,
    output logic                   instrDone,
    output logic                   illegalOp,
    output logic [STALL_CNT_W-1:0] stallCnt,
    output logic [3:0]             state
);

    state_t                   r_state;
    state_t                   w_next_state;
    ctrl_word_t               w_dec_ctrl;
    ctrl_word_t               w_ctrl;
    logic [STALL_CNT_W-1:0]   r_stall_cnt;
    logic                     w_stall;

    ctrl_output_decoder u_decoder (
        .state     (r_state),
        .op        (op),
        .zero      (zero),
        .mem_ready (memReady),
        .ctrl      (w_dec_ctrl)
    );

    // Reset silences every strobe so an abandoned instruction writes nothing.
    assign w_ctrl  = rst ? '0 : w_dec_ctrl;
    assign w_stall = w_ctrl.mem_req & ~memReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH:    w_next_state = memReady ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    c_op_lw, c_op_sw: w_next_state = MEMADR;
                    c_op_rtype:       w_next_state = EXECR;
                    c_op_addi:        w_next_state = EXECI;
                    c_op_beq:         w_next_state = BEQ;
                    default:          w_next_state = ILLEGAL;
                endcase
            end
            MEMADR:   w_next_state = (op == c_op_sw) ? MEMWRITE : MEMREAD;
            MEMREAD:  w_next_state = memReady ? MEMWB : MEMREAD;
            MEMWRITE: w_next_state = memReady ? FETCH : MEMWRITE;
            EXECR:    w_next_state = ALUWB;
            EXECI:    w_next_state = ALUWB;
            default:  w_next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign memReq     = w_ctrl.mem_req;
    assign memWe      = w_ctrl.mem_we;
    assign AdrSrc     = w_ctrl.adr_src;
    assign IRWrite    = w_ctrl.ir_write;
    assign PCWrite    = w_ctrl.pc_write;
    assign RegWrite   = w_ctrl.reg_write;
    assign ALUSrcA    = w_ctrl.alu_src_a;
    assign ALUSrcB    = w_ctrl.alu_src_b;
    assign ALUControl = w_ctrl.alu_control;
    assign ResultSrc  = w_ctrl.result_src;
    assign ImmSrc     = w_ctrl.imm_src;
    assign instrDone  = w_ctrl.instr_done;
    assign illegalOp  = w_ctrl.illegal_op;
    assign stallCnt   = r_stall_cnt;
    assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
//------------------------------------------------------------------------------
// Module  : tb_multicycle_control_fsm
// Brief   : Directed scoreboard bench for the multi-cycle controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control_fsm;

    localparam logic [3:0] S_F  = 4'd0, S_D  = 4'd1, S_MA = 4'd2, S_MR = 4'd3;
    localparam logic [3:0] S_MW = 4'd4, S_WR = 4'd5, S_ER = 4'd6, S_EI = 4'd7;
    localparam logic [3:0] S_AW = 4'd8, S_BQ = 4'd9, S_IL = 4'd10;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011, OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011, OP_X  = 7'b1111111;

    localparam time C_TIMEOUT = 100000;

    // {state, req, we, adr, irw, pcw, rw, srca, srcb, alu, res, imm, done, ill, stall}
    typedef struct packed {
        logic [3:0] st;
        logic [5:0] strb;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic [1:0] res;
        logic [1:0] imm;
        logic [1:0] flags;
        logic [1:0] stall;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       memReady;
    logic       memReq, memWe, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;
    logic       instrDone, illegalOp;
    logic [1:0] stallCnt;
    logic [3:0] state;

    exp_t  q_exp[$];
    string q_name[$];
    int    checks = 0;
    int    errors = 0;
    exp_t  act;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.STALL_CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .zero       (zero),
        .memReady   (memReady),
        .memReq     (memReq),
        .memWe      (memWe),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .instrDone  (instrDone),
        .illegalOp  (illegalOp),
        .stallCnt   (stallCnt),
        .state      (state)
    );

    assign act = {state, memReq, memWe, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc,
                  instrDone, illegalOp, stallCnt};

    function automatic exp_t mk(input logic [3:0] st, input logic [5:0] strb,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic [2:0] alu, input logic [1:0] res,
                                input logic [1:0] imm, input logic [1:0] flags,
                                input logic [1:0] stall);
        return {st, strb, sa, sb, alu, res, imm, flags, stall};
    endfunction

    // Expected values are queued at posedge+1; the monitor consumes them mid-cycle.
    task automatic step(input string nm, input logic r, input logic [6:0] o,
                        input logic z, input logic rdy, input exp_t e, input logic chk);
        rst      = r;
        op       = o;
        zero     = z;
        memReady = rdy;
        if (chk) begin
            q_name.push_back(nm);
            q_exp.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string p, input logic [6:0] o, input logic z,
                                input logic [1:0] stall);
        step({p, "_fetch"}, 1'b0, o, z, 1'b1,
             mk(S_F, 6'b100110, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 2'b00, stall), 1'b1);
        step({p, "_decode"}, 1'b0, o, z, 1'b1,
             mk(S_D, 6'b000000, 2'b01, 2'b01, 3'b000, 2'b00, 2'b10, 2'b00, stall), 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n = q_name.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
    end

    initial begin
        #(C_TIMEOUT);
        errors++;
        $display("FAIL timeout: sequence did not finish within %0t", C_TIMEOUT);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        step("rst0", 1'b1, 7'h00, 1'b0, 1'b0, '0, 1'b0);
        step("reset", 1'b1, 7'h00, 1'b0, 1'b0, mk(S_F, 6'b0, 2'b0, 2'b0, 3'b0, 2'b0, 2'b0, 2'b0, 2'd0), 1'b1);
        checks++;
        if ((state !== S_F) || (stallCnt !== 2'd0) || (act[25:2] !== '0)) begin
            errors++;
            $display("FAIL reset_state: state %h stallCnt %h ctrl %h", state, stallCnt, act[25:2]);
        end

        // lw, zero-wait memory
        fetch_decode("lw", OP_LW, 1'b0, 2'd0);
        step("lw_memadr", 1'b0, OP_LW, 1'b0, 1'b1, mk(S_MA, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 2'd0), 1'b1);
        step("lw_memread", 1'b0, OP_LW, 1'b0, 1'b1, mk(S_MR, 6'b101000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'd0), 1'b1);
        step("lw_memwb", 1'b0, OP_LW, 1'b0, 1'b1, mk(S_MW, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 2'b10, 2'd0), 1'b1);

        // sw with three wait cycles in MEMWRITE
        fetch_decode("sw", OP_SW, 1'b0, 2'd0);
        step("sw_memadr", 1'b0, OP_SW, 1'b0, 1'b1, mk(S_MA, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 2'b01, 2'b00, 2'd0), 1'b1);
        for (int k = 0; k < 3; k++)
            step("sw_wait", 1'b0, OP_SW, 1'b0, 1'b0, mk(S_WR, 6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'(k)), 1'b1);
        step("sw_done", 1'b0, OP_SW, 1'b0, 1'b1, mk(S_WR, 6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b10, 2'd3), 1'b1);

        // beq taken then not taken; stall count survives retire
        fetch_decode("beqt", OP_B, 1'b1, 2'd3);
        step("beqt_exec", 1'b0, OP_B, 1'b1, 1'b1, mk(S_BQ, 6'b000010, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 2'b10, 2'd3), 1'b1);
        fetch_decode("beqn", OP_B, 1'b0, 2'd3);
        step("beqn_exec", 1'b0, OP_B, 1'b0, 1'b1, mk(S_BQ, 6'b000000, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 2'b10, 2'd3), 1'b1);

        // R-type and addi
        fetch_decode("rtype", OP_R, 1'b0, 2'd3);
        step("rtype_exec", 1'b0, OP_R, 1'b0, 1'b1, mk(S_ER, 6'b000000, 2'b10, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'd3), 1'b1);
        step("rtype_wb", 1'b0, OP_R, 1'b0, 1'b1, mk(S_AW, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b10, 2'd3), 1'b1);
        fetch_decode("addi", OP_I, 1'b0, 2'd3);
        step("addi_exec", 1'b0, OP_I, 1'b0, 1'b1, mk(S_EI, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 2'd3), 1'b1);
        step("addi_wb", 1'b0, OP_I, 1'b0, 1'b1, mk(S_AW, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b10, 2'd3), 1'b1);

        // unsupported opcode
        fetch_decode("ill", OP_X, 1'b0, 2'd3);
        step("ill_pulse", 1'b0, OP_X, 1'b0, 1'b1, mk(S_IL, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 2'd3), 1'b1);

        // reset during a MEMREAD wait
        fetch_decode("lwr", OP_LW, 1'b0, 2'd3);
        step("lwr_memadr", 1'b0, OP_LW, 1'b0, 1'b1, mk(S_MA, 6'b000000, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 2'd3), 1'b1);
        step("lwr_wait", 1'b0, OP_LW, 1'b0, 1'b0, mk(S_MR, 6'b101000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'd3), 1'b1);
        step("lwr_rst", 1'b1, OP_LW, 1'b0, 1'b0, mk(S_MR, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'd3), 1'b1);

        // FETCH stalled six cycles: counter climbs from 0 and pins at 3
        for (int k = 0; k < 6; k++)
            step("sat_fetch", 1'b0, OP_I, 1'b0, 1'b0,
                 mk(S_F, 6'b100000, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 2'b00, (k > 3) ? 2'd3 : 2'(k)), 1'b1);
        fetch_decode("sat", OP_I, 1'b0, 2'd3);

        step("drain", 1'b0, OP_I, 1'b0, 1'b1, '0, 1'b0);
        step("drain", 1'b0, OP_I, 1'b0, 1'b1, '0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
